// File: rtl/bus_pkg.sv
// Shared definitions for the master/slave serial bus: FSM encoding and
// default transfer geometry.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RECEIVE = 2'd2
   } state_t;

   localparam int DEFAULT_DATA_WIDTH     = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/serial_shift_in.sv
// LSB-first shift-in register with bit counter; o_next_word is the word as it
// will look once the current bit is taken, so the last bit can be captured directly.
module serial_shift_in
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_clear,
   input  logic                  i_shift,
   input  logic                  i_bit,
   output logic [DATA_WIDTH-1:0] o_next_word,
   output logic                  o_last_bit
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] r_word;
   logic [BW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] w_next_word;

   // Shifting right lands bit k at position k after DATA_WIDTH shifts.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
         assign w_next_word[gi] = r_word[gi+1];
      end
   endgenerate
   assign w_next_word[DATA_WIDTH-1] = i_bit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_clear) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_shift) begin
         r_word <= w_next_word;
         r_cnt  <= r_cnt + BW'(1);
      end
   end

   assign o_next_word = w_next_word;
   assign o_last_bit  = (r_cnt == LAST_IDX);

endmodule

// File: rtl/master_in_port.sv
// Master receive stage: request/handshake with the slave, bounded wait, then
// LSB-first deserialisation of one word with done/timeout/frame-error status.
module master_in_port
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_start,
   input  logic                  slave_valid,
   input  logic                  slave_tx_done,
   input  logic                  rx_data,
   output logic                  master_ready,
   output logic [DATA_WIDTH-1:0] dataout,
   output logic                  rx_done,
   output logic                  rx_busy,
   output logic                  rx_timeout,
   output logic                  frame_err
);

   localparam logic [CNT_WIDTH-1:0] TC_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t                r_state, w_state_next;
   logic [CNT_WIDTH-1:0]  r_tcnt, w_tcnt_next;
   logic [DATA_WIDTH-1:0] r_dataout, w_dataout_next;
   logic                  r_rx_done, w_rx_done_next;
   logic                  r_rx_timeout, w_rx_timeout_next;
   logic                  r_frame_err, w_frame_err_next;
   logic                  w_clear, w_shift, w_last_bit;
   logic [DATA_WIDTH-1:0] w_next_word;

   serial_shift_in #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_clear),
      .i_shift     (w_shift),
      .i_bit       (rx_data),
      .o_next_word (w_next_word),
      .o_last_bit  (w_last_bit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_tcnt       <= '0;
         r_dataout    <= '0;
         r_rx_done    <= 1'b0;
         r_rx_timeout <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_tcnt       <= w_tcnt_next;
         r_dataout    <= w_dataout_next;
         r_rx_done    <= w_rx_done_next;
         r_rx_timeout <= w_rx_timeout_next;
         r_frame_err  <= w_frame_err_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_tcnt_next       = r_tcnt;
      w_dataout_next    = r_dataout;
      w_rx_done_next    = 1'b0;
      w_rx_timeout_next = 1'b0;
      w_frame_err_next  = r_frame_err;
      w_clear           = 1'b0;
      w_shift           = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_start) begin
               w_state_next     = WAIT;
               w_tcnt_next      = '0;
               w_frame_err_next = 1'b0;
            end
         end
         WAIT: begin
            // Handshake is checked first so it beats a coincident expiry.
            if (slave_valid) begin
               w_state_next = RECEIVE;
               w_clear      = 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && r_tcnt == TC_LAST) begin
               w_state_next      = IDLE;
               w_rx_timeout_next = 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
               w_tcnt_next = r_tcnt + CNT_WIDTH'(1);
            end
         end
         RECEIVE: begin
            w_shift = 1'b1;
            if (w_last_bit) begin
               w_state_next   = IDLE;
               w_dataout_next = w_next_word;
               w_rx_done_next = 1'b1;
               if (!slave_tx_done) w_frame_err_next = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign master_ready = (r_state == WAIT);
   assign rx_busy      = (r_state != IDLE);
   assign dataout      = r_dataout;
   assign rx_done      = r_rx_done;
   assign rx_timeout   = r_rx_timeout;
   assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_master_in_port.sv
// Self-checking bench for master_in_port: vector table, directed corner cases
// and randomized transfers against a transaction-level expectation model.
module tb_master_in_port;

   localparam int DW = 8;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rx_start = 1'b0;
   logic          slave_valid = 1'b0;
   logic          slave_tx_done = 1'b0;
   logic          rx_data = 1'b0;
   logic          master_ready;
   logic [DW-1:0] dataout;
   logic          rx_done;
   logic          rx_busy;
   logic          rx_timeout;
   logic          frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   master_in_port #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_start      (rx_start),
      .slave_valid   (slave_valid),
      .slave_tx_done (slave_tx_done),
      .rx_data       (rx_data),
      .master_ready  (master_ready),
      .dataout       (dataout),
      .rx_done       (rx_done),
      .rx_busy       (rx_busy),
      .rx_timeout    (rx_timeout),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%b exp=%b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%02h exp=%02h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request: slave_valid appears after 'delay' WAIT cycles; the slave then
   // sends 'word' LSB first with slave_tx_done on the last bit only if txd.
   task automatic run_xfer(input logic [DW-1:0] word, input int delay, input bit txd,
                           input bit exp_to, input logic [DW-1:0] exp_dout, input bit exp_ferr);
      bit hs = 0;
      bit saw_to = 0;
      int lat = 0;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      chk1("wait_ready", master_ready, 1'b1);
      chk1("start_clears_ferr", frame_err, 1'b0);
      for (int k = 0; k < TO + 2; k++) begin
         slave_valid = (k >= delay);
         tick();
         if (rx_timeout) begin saw_to = 1; break; end
         if (!master_ready && rx_busy) begin hs = 1; break; end
      end
      slave_valid = 1'b0;
      chk1("timeout_flag", saw_to, exp_to);
      if (saw_to) begin
         chk1("to_idle", rx_busy, 1'b0);
         chk8("to_dout_kept", dataout, exp_dout);
         tick();
         chk1("to_one_cycle", rx_timeout, 1'b0);
      end else if (hs) begin
         for (int j = 1; j <= DW + 3; j++) begin
            rx_data       = (j <= DW) ? word[3'(j-1)] : 1'b0;
            slave_tx_done = (j == DW) && txd;
            slave_valid   = 1'($urandom);
            rx_start      = 1'($urandom);
            tick();
            if (rx_done) begin lat = j + 1; break; end
         end
         rx_start = 1'b0; slave_valid = 1'b0; slave_tx_done = 1'b0; rx_data = 1'b0;
         chki("latency", lat, DW + 1);
         chk8("dataout", dataout, exp_dout);
         chk1("frame_err", frame_err, exp_ferr);
         tick();
         chk1("done_one_cycle", rx_done, 1'b0);
         chk1("back_idle", rx_busy, 1'b0);
      end else begin
         chk1("no_progress", 1'b1, 1'b0);
      end
      tick();
      chk1("sticky_ferr", frame_err, exp_ferr);
   endtask

   typedef struct {
      logic [DW-1:0] word;
      int            delay;
      bit            txd;
      bit            exp_to;
      logic [DW-1:0] exp_dout;
      bit            exp_ferr;
   } vec_t;

   vec_t vecs[8];
   logic [DW-1:0] m_dout;
   bit            m_ferr;

   initial begin
      vecs[0] = '{8'h5A, 4, 1'b1, 1'b1, 8'h00, 1'b0};
      vecs[1] = '{8'hA5, 2, 1'b1, 1'b0, 8'hA5, 1'b0};
      vecs[2] = '{8'h3C, 0, 1'b0, 1'b0, 8'h3C, 1'b1};
      vecs[3] = '{8'h77, 3, 1'b1, 1'b0, 8'h77, 1'b0};
      vecs[4] = '{8'h12, 5, 1'b1, 1'b1, 8'h77, 1'b0};
      vecs[5] = '{8'h00, 1, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'hFF, 4, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[7] = '{8'hC3, 0, 1'b1, 1'b0, 8'hC3, 1'b0};

      reset = 1'b1;
      tick(); tick();
      chk1("rst_ready", master_ready, 1'b0);
      chk8("rst_dout", dataout, 8'h00);
      chk1("rst_done", rx_done, 1'b0);
      chk1("rst_busy", rx_busy, 1'b0);
      chk1("rst_to", rx_timeout, 1'b0);
      chk1("rst_ferr", frame_err, 1'b0);
      @(negedge clk) reset = 1'b0;
      tick();

      foreach (vecs[i]) begin
         run_xfer(vecs[i].word, vecs[i].delay, vecs[i].txd,
                  vecs[i].exp_to, vecs[i].exp_dout, vecs[i].exp_ferr);
         $display("vec %0d word=%02h delay=%0d txd=%0d dout=%02h ferr=%0d",
                  i, vecs[i].word, vecs[i].delay, vecs[i].txd, dataout, frame_err);
      end

      // Reset after bit 3 of 0x81: everything returns to reset values at once.
      begin
         logic [DW-1:0] w;
         w = 8'h81;
         rx_start = 1'b1; tick(); rx_start = 1'b0;
         slave_valid = 1'b1; tick(); slave_valid = 1'b0;
         for (int b = 0; b < 4; b++) begin
            rx_data = w[3'(b)];
            tick();
         end
         #2 reset = 1'b1;
         #1;
         chk1("amid_ready", master_ready, 1'b0);
         chk1("amid_busy", rx_busy, 1'b0);
         chk8("amid_dout", dataout, 8'h00);
         chk1("amid_done", rx_done, 1'b0);
         for (int b = 4; b < 8; b++) begin
            rx_data = w[3'(b)];
            tick();
            chk1("amid_no_done", rx_done, 1'b0);
         end
         @(negedge clk) reset = 1'b0;
         rx_data = 1'b0;
         tick();
         run_xfer(8'h81, 1, 1'b1, 1'b0, 8'h81, 1'b0);
         $display("reset_mid: dout=%02h", dataout);
      end

      // Back-to-back with rx_start held high; slave modelled at handshake level.
      begin
         logic [DW-1:0] words[2];
         logic [DW-1:0] cur;
         logic [DW-1:0] got[2];
         int t_done[2];
         int n = 0, hcount = 0, idx = 0;
         bit active = 0, hs_now;
         words[0] = 8'hFF; words[1] = 8'h00;
         cur = 8'h00;
         rx_start = 1'b1; slave_valid = 1'b1;
         for (int e = 0; e < 40 && n < 2; e++) begin
            hs_now        = master_ready && slave_valid;
            rx_data       = active ? cur[3'(idx)] : 1'b0;
            slave_tx_done = active && (idx == DW - 1);
            tick();
            if (active) begin
               idx++;
               if (idx == DW) active = 0;
            end
            if (hs_now) begin
               active = 1; idx = 0;
               cur = words[hcount % 2];
               hcount++;
            end
            if (rx_done) begin
               got[n] = dataout; t_done[n] = cyc; n++;
            end
         end
         rx_start = 1'b0; slave_valid = 1'b0; rx_data = 1'b0; slave_tx_done = 1'b0;
         chki("b2b_count", n, 2);
         if (n == 2) begin
            chk8("b2b_word0", got[0], 8'hFF);
            chk8("b2b_word1", got[1], 8'h00);
            chki("b2b_gap", t_done[1] - t_done[0], 10);
         end
         tick(); tick();
         $display("b2b: pulses=%0d", n);
         m_dout = 8'h00;
      end

      // Randomized transfers checked against the transaction-level model.
      for (int r = 0; r < 24; r++) begin
         logic [DW-1:0] w;
         int d;
         bit t, e_to;
         w = DW'($urandom);
         d = $urandom_range(0, TO + 1);
         t = 1'($urandom);
         e_to = (d >= TO);
         if (!e_to) begin
            m_dout = w;
            m_ferr = !t;
         end else begin
            m_ferr = 1'b0;
         end
         run_xfer(w, d, t, e_to, m_dout, m_ferr);
         $display("rand %0d word=%02h delay=%0d txd=%0d to=%0d dout=%02h",
                  r, w, d, t, e_to, dataout);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/master_in_port.md
Name: master_in_port

Overview:
- Master-side receive stage that consumes the serial stream produced by the slave output port.
- On a core read request it raises master_ready and waits for slave_valid. After the handshake it samples rx_data LSB-first for DATA_WIDTH cycles and presents the assembled word with a one-cycle done pulse.
- Bounded wait: the request is abandoned with a timeout indication if the slave never becomes valid.

Parameters:
- DATA_WIDTH, 8: bits per transfer; matches the slave serializer.
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before abandoning the request; 0 disables the timeout.
- CNT_WIDTH, 8: width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- rx_start  input  1  core request to receive one word; sampled only in IDLE
- slave_valid  input  1  slave has data ready
- slave_tx_done  input  1  slave is driving its last bit
- rx_data  input  1  serial data from slave, LSB first
- master_ready  output  1  master ready for handshake
- dataout  output  DATA_WIDTH  last successfully received word
- rx_done  output  1  one-cycle pulse: dataout updated
- rx_busy  output  1  high in WAIT and RECEIVE
- rx_timeout  output  1  one-cycle pulse: request abandoned
- frame_err  output  1  sticky: slave_tx_done was low on the last bit; cleared by next rx_start accepted in IDLE

Behaviour:
- Reset (async, active-high): state=IDLE. master_ready=0, dataout=0, rx_done=0, rx_busy=0, rx_timeout=0, frame_err=0. Shift register, bit counter and timeout counter all cleared.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- States: IDLE, WAIT, RECEIVE.
- IDLE:
  - rx_start=1 → WAIT; clear timeout counter; clear frame_err.
  - Otherwise stay.
- WAIT:
  - master_ready=1 and rx_busy=1.
  - Handshake is slave_valid & master_ready sampled at a rising edge. On handshake → RECEIVE, bit_cnt=0.
  - Else, if TIMEOUT_CYCLES≠0 and the counter has reached TIMEOUT_CYCLES-1 → IDLE, with rx_timeout pulsed on the following cycle.
  - Else increment the counter.
- RECEIVE:
  - master_ready=0, rx_busy=1.
  - Each edge shifts rx_data into position bit_cnt (LSB first) and increments bit_cnt. The slave drives bit k during the (k+1)th cycle after the handshake edge.
  - On the edge sampling bit DATA_WIDTH-1:
    - if slave_tx_done=0, set frame_err;
    - load dataout with the full word (bit 7 included);
    - pulse rx_done for exactly one cycle;
    - go to IDLE.
- Latency: handshake edge to rx_done high is DATA_WIDTH+1 edges (9 for the default).
- dataout is updated only on rx_done; a timeout leaves dataout unchanged.
- rx_start outside IDLE is ignored. There is no queuing.
- rx_start high continuously makes back-to-back transfers; IDLE costs one cycle between transfers.
- slave_valid dropping mid-RECEIVE is ignored; the transfer completes on count.
- Reset mid-RECEIVE aborts the transfer: no rx_done, dataout=0.
- Simultaneous handshake and timeout expiry in WAIT: the handshake wins.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding constants IDLE/WAIT/RECEIVE;
  - the default DATA_WIDTH;
  - the default TIMEOUT_CYCLES.
- One natural sub-module, serial_shift_in: a DATA_WIDTH shift-in register with shift enable, clear and bit counter, exposing a last_bit flag. The FSM and timeout counter stay in master_in_port.

Test Plan:
1. Basic receive:
   - Stimulus: rx_start pulse; slave_valid=1 two cycles later; rx_data drives 0xA5 LSB-first (1,0,1,0,0,1,0,1); slave_tx_done high on bit 7.
   - Response: rx_done pulses 9 edges after the handshake; dataout=0xA5; frame_err=0; master_ready low from the handshake onward.
2. Timeout, TIMEOUT_CYCLES=4:
   - Stimulus: rx_start with slave_valid held 0.
   - Response: master_ready high 4 cycles, then rx_timeout pulses once; state IDLE; dataout keeps its prior value (0x00 after reset).
3. Frame error:
   - Stimulus: receive 0x3C with slave_tx_done held 0.
   - Response: dataout=0x3C, rx_done pulses, frame_err=1 and stays set. The next accepted rx_start clears it.
4. Back-to-back:
   - Stimulus: rx_start held high; slave sends 0xFF then 0x00.
   - Response: two rx_done pulses separated by 10 cycles (1-cycle IDLE + 9); dataout 0xFF then 0x00.
5. Reset mid-operation:
   - Stimulus: assert reset after bit 3 of 0x81.
   - Response: all outputs go to reset values immediately (async); no rx_done. A later full transfer of 0x81 completes correctly.
6. Ignored request and race:
   - rx_start pulsed during RECEIVE → no effect on the current word.
   - Handshake on the same edge the timeout would expire → RECEIVE entered, no rx_timeout.
